// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the arithmetic-unit command sequencer.
package alu_seq_pkg;

   localparam int OP_W  = 3;
   localparam int RES_W = 6;

   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_MUL = 2'b10;
   localparam logic [1:0] SEL_DIV = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESULT
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic [1:0]      sel;
   } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_fifo.sv
// Command FIFO: storage, wrap-bit pointers, full/empty flags and occupancy.
module alu_cmd_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          wr_data,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   import alu_seq_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered commands to an external arithmetic unit one at a time and
// holds each result in a valid/ready output register.
module alu_op_sequencer #(
   parameter int DEPTH = 4,
   parameter int OP_W  = 3,
   parameter int RES_W = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [OP_W-1:0]           cmd_a,
   input  logic [OP_W-1:0]           cmd_b,
   input  logic [1:0]                cmd_sel,
   output logic [OP_W-1:0]           alu_a,
   output logic [OP_W-1:0]           alu_b,
   output logic [1:0]                alu_sel,
   input  logic [RES_W-1:0]          alu_result,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [RES_W-1:0]          res_data,
   output logic [1:0]                res_sel,
   output logic                      res_divzero,
   output logic                      drop_sticky,
   output logic [$clog2(DEPTH):0]    level
);
   import alu_seq_pkg::*;

   localparam int CMD_W = 2*OP_W + 2;

   state_t             state_q, state_d;
   logic [OP_W-1:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [1:0]         alu_sel_q, alu_sel_d;
   logic               res_valid_q, res_valid_d;
   logic [RES_W-1:0]   res_data_q, res_data_d;
   logic [1:0]         res_sel_q, res_sel_d;
   logic               res_divzero_q, res_divzero_d;
   logic               drop_sticky_q, drop_sticky_d;

   logic               fifo_full, fifo_empty, pop;
   logic [CMD_W-1:0]   fifo_rd_data;
   logic               div_by_zero;

   alu_cmd_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push    (cmd_valid),
      .pop     (pop),
      .wr_data ({cmd_a, cmd_b, cmd_sel}),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   assign div_by_zero = (alu_sel_q == SEL_DIV) && (alu_b_q == '0);

   // Clear overrides the FSM step, so a pop decided this cycle is cancelled too.
   always_comb begin
      state_d       = state_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_sel_d     = alu_sel_q;
      res_valid_d   = res_valid_q;
      res_data_d    = res_data_q;
      res_sel_d     = res_sel_q;
      res_divzero_d = res_divzero_q;
      drop_sticky_d = drop_sticky_q || (cmd_valid && fifo_full);
      pop           = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            res_data_d    = div_by_zero ? '0 : alu_result;
            res_sel_d     = alu_sel_q;
            res_divzero_d = div_by_zero;
            res_valid_d   = 1'b1;
            state_d       = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (clear) begin
         state_d       = IDLE;
         res_valid_d   = 1'b0;
         res_divzero_d = 1'b0;
         drop_sticky_d = 1'b0;
         pop           = 1'b0;
      end

      if (pop) {alu_a_d, alu_b_d, alu_sel_d} = fifo_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_sel_q     <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_sel_q     <= '0;
         res_divzero_q <= 1'b0;
         drop_sticky_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_sel_q     <= alu_sel_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         res_sel_q     <= res_sel_d;
         res_divzero_q <= res_divzero_d;
         drop_sticky_q <= drop_sticky_d;
      end
   end

   assign cmd_ready   = !fifo_full;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_sel     = alu_sel_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_sel     = res_sel_q;
   assign res_divzero = res_divzero_q;
   assign drop_sticky = drop_sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and randomized bench for alu_op_sequencer with an external
// arithmetic unit model and a scoreboard of expected results in push order.
module tb_alu_op_sequencer;
   import alu_seq_pkg::*;

   logic       clk, rst_n, clear;
   logic       cmd_valid, cmd_ready;
   logic [2:0] cmd_a, cmd_b;
   logic [1:0] cmd_sel;
   logic [2:0] alu_a, alu_b;
   logic [1:0] alu_sel;
   logic [5:0] alu_result;
   logic       res_valid, res_ready;
   logic [5:0] res_data;
   logic [1:0] res_sel;
   logic       res_divzero, drop_sticky;
   logic [2:0] level;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [5:0] data;
      logic [1:0] sel;
      logic       dz;
   } exp_t;

   exp_t expQ[$];
   exp_t monE;
   exp_t holdE;
   logic [2:0] ha, hb;
   logic [1:0] hs;

   alu_op_sequencer #(.DEPTH(4), .OP_W(3), .RES_W(6)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .cmd_sel     (cmd_sel),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_result  (alu_result),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_sel     (res_sel),
      .res_divzero (res_divzero),
      .drop_sticky (drop_sticky),
      .level       (level)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External arithmetic unit; a zero divisor yields garbage the sequencer must mask.
   function automatic logic [5:0] arithUnit(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
      logic [5:0] ea, eb;
      ea = {3'b000, a};
      eb = {3'b000, b};
      case (sel)
         2'b00:   return ea + eb;
         2'b01:   return ea - eb;
         2'b10:   return ea * eb;
         default: return (b == 3'd0) ? 6'h3F : ea / eb;
      endcase
   endfunction

   assign alu_result = arithUnit(alu_a, alu_b, alu_sel);

   function automatic exp_t refModel(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
      exp_t e;
      int   ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (sel)
         SEL_ADD: r = ia + ib;
         SEL_SUB: r = ia - ib;
         SEL_MUL: r = ia * ib;
         default: r = (ib == 0) ? 0 : ia / ib;
      endcase
      e.data = 6'(r);
      e.sel  = sel;
      e.dz   = (sel == SEL_DIV) && (ib == 0);
      return e;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
      cmd_a     = a;
      cmd_b     = b;
      cmd_sel   = sel;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic waitValid(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (res_valid) break;
         step();
      end
      checkOutput("wait_res_valid", res_valid, 1);
   endtask

   task automatic consumeOne();
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
   endtask

   task automatic drainAll(input int budget);
      res_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (expQ.size() == 0 && level == 3'd0 && !res_valid) break;
      end
      res_ready = 1'b0;
      checkOutput("drain_queue_empty", expQ.size(), 0);
      checkOutput("drain_level", level, 0);
   endtask

   task automatic checkReset();
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_res_divzero", res_divzero, 0);
      checkOutput("rst_drop_sticky", drop_sticky, 0);
      checkOutput("rst_res_data", res_data, 0);
      checkOutput("rst_res_sel", res_sel, 0);
      checkOutput("rst_alu_a", alu_a, 0);
      checkOutput("rst_alu_b", alu_b, 0);
      checkOutput("rst_alu_sel", alu_sel, 0);
   endtask

   // Scoreboard: inputs are stable from #1 after a rising edge, so the falling
   // edge sees exactly what the next rising edge will act on.
   always @(negedge clk) begin
      if (rst_n) begin
         if (clear) begin
            expQ.delete();
         end else begin
            if (res_valid && res_ready) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_result", 1, 0);
               end else begin
                  monE = expQ.pop_front();
                  checkOutput("sb_res_data", res_data, monE.data);
                  checkOutput("sb_res_sel", res_sel, monE.sel);
                  checkOutput("sb_res_divzero", res_divzero, monE.dz);
               end
            end
            if (cmd_valid && cmd_ready) expQ.push_back(refModel(cmd_a, cmd_b, cmd_sel));
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_sel   = '0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkReset();
      rst_n = 1'b1;
      step();

      // Single add: result two edges after the push.
      applyStimulus(3'd3, 3'd2, SEL_ADD);
      checkOutput("t1_level_pushed", level, 1);
      checkOutput("t1_valid_n0", res_valid, 0);
      step();
      checkOutput("t1_alu_a", alu_a, 3);
      checkOutput("t1_alu_b", alu_b, 2);
      checkOutput("t1_level_popped", level, 0);
      checkOutput("t1_valid_n1", res_valid, 0);
      step();
      checkOutput("t1_valid_n2", res_valid, 1);
      checkOutput("t1_res_data", res_data, 5);
      checkOutput("t1_res_sel", res_sel, 0);
      consumeOne();
      checkOutput("t1_valid_consumed", res_valid, 0);

      // Fill: one command in flight plus four buffered, then a dropped sixth.
      for (int i = 0; i < 5; i++)
         applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      checkOutput("t2_level_full", level, 4);
      checkOutput("t2_cmd_ready", cmd_ready, 0);
      checkOutput("t2_valid", res_valid, 1);
      applyStimulus(3'd7, 3'd7, SEL_MUL);
      checkOutput("t2_drop_sticky", drop_sticky, 1);
      step();
      step();
      checkOutput("t2_level_hold", level, 4);
      checkOutput("t2_valid_hold", res_valid, 1);

      // Drain: a result every second edge, in push order.
      res_ready = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         checkOutput("t2_drain_valid", res_valid, ((k % 2) == 0) ? 1 : 0);
      end
      res_ready = 1'b0;
      checkOutput("t2_drain_level", level, 0);
      checkOutput("t2_drain_queue", expQ.size(), 0);
      checkOutput("t2_drop_kept", drop_sticky, 1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      checkOutput("t2_drop_cleared", drop_sticky, 0);

      // Divide by zero masks the unit's output.
      applyStimulus(3'd5, 3'd0, SEL_DIV);
      waitValid(10);
      checkOutput("t3_divzero", res_divzero, 1);
      checkOutput("t3_data_zero", res_data, 0);
      checkOutput("t3_sel", res_sel, 3);
      consumeOne();
      applyStimulus(3'd6, 3'd3, SEL_DIV);
      waitValid(10);
      checkOutput("t3_divzero_clear", res_divzero, 0);
      checkOutput("t3_div_data", res_data, 2);
      consumeOne();

      // Back-pressure: everything holds while res_ready is low.
      ha = 3'($urandom_range(0, 7));
      hb = 3'($urandom_range(0, 7));
      hs = 2'($urandom_range(0, 3));
      holdE = refModel(ha, hb, hs);
      applyStimulus(ha, hb, hs);
      waitValid(10);
      for (int k = 0; k < 5; k++) begin
         step();
         checkOutput("t4_valid", res_valid, 1);
         checkOutput("t4_res_data", res_data, holdE.data);
         checkOutput("t4_res_sel", res_sel, holdE.sel);
         checkOutput("t4_res_divzero", res_divzero, holdE.dz);
         checkOutput("t4_alu_a", alu_a, ha);
         checkOutput("t4_alu_b", alu_b, hb);
         checkOutput("t4_alu_sel", alu_sel, hs);
      end
      consumeOne();

      // Random traffic with random back-pressure against the scoreboard.
      for (int i = 0; i < 80; i++) begin
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_a     = 3'($urandom_range(0, 7));
         cmd_b     = 3'($urandom_range(0, 7));
         cmd_sel   = 2'($urandom_range(0, 3));
         res_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      cmd_valid = 1'b0;
      drainAll(100);
      clear = 1'b1;
      step();
      clear = 1'b0;

      // Asynchronous reset mid-operation.
      for (int i = 0; i < 4; i++)
         applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      checkOutput("t5_level3", level, 3);
      checkOutput("t5_valid", res_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      expQ.delete();
      checkReset();
      step();
      rst_n = 1'b1;
      step();
      checkOutput("t5_post_rst_level", level, 0);
      checkOutput("t5_post_rst_valid", res_valid, 0);

      // Clear with a simultaneous push, while full and with drop_sticky set.
      for (int i = 0; i < 6; i++)
         applyStimulus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      checkOutput("t6_level_full", level, 4);
      checkOutput("t6_drop_set", drop_sticky, 1);
      clear     = 1'b1;
      cmd_valid = 1'b1;
      step();
      clear     = 1'b0;
      cmd_valid = 1'b0;
      checkOutput("t6_level", level, 0);
      checkOutput("t6_valid", res_valid, 0);
      checkOutput("t6_drop", drop_sticky, 0);
      checkOutput("t6_cmd_ready", cmd_ready, 1);
      step();
      checkOutput("t6_level_after", level, 0);
      checkOutput("t6_valid_after", res_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
